// File: rtl/sr_cpu_multicycle_pkg.sv
// sr_cpu_multicycle_pkg: opcodes, funct fields, ALU/FSM/writeback enums and immediate decode
package sr_cpu_multicycle_pkg;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLL, ALU_SRL, ALU_SLTU} aluOp_t;
    typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, WRITEBACK, HALT} state_t;
    typedef enum logic [1:0] {WD_ALU, WD_IMMU, WD_PC4} wdSrc_t;

    function automatic logic [31:0] immGen(input logic [31:0] ir);
        return ir[6:0] == OP_IMM    ? {{20{ir[31]}}, ir[31:20]} :
               ir[6:0] == OP_LUI    ? {ir[31:12], 12'b0} :
               ir[6:0] == OP_BRANCH ? {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0} :
               ir[6:0] == OP_JAL    ? {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0} : 32'b0;
    endfunction
endpackage

// File: rtl/sr_cpu_multicycle_if.sv
// sr_cpu_multicycle_if: instruction fetch request/valid handshake
interface sr_cpu_multicycle_if;
    logic        imReq;
    logic [31:0] imAddr;
    logic        imValid;
    logic [31:0] imData;
    modport master(output imReq, imAddr, input imValid, imData);
    modport slave(input imReq, imAddr, output imValid, imData);
endinterface

// File: rtl/sr_mc_control.sv
// sr_mc_control: FETCH/DECODE/EXECUTE/WRITEBACK/HALT FSM, legality check and datapath strobes
module sr_mc_control
    import sr_cpu_multicycle_pkg::*;
#(
    parameter int NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ir,
    input  logic        imValid,
    output logic        imReq,
    output logic        irWrite,
    output logic        regWrite,
    output logic        pcWrite,
    output logic        aluSrcImm,
    output logic        branch,
    output logic        jump,
    output logic        halted,
    output logic        retire,
    output wdSrc_t      wdSrc,
    output aluOp_t      aluControl
);
    state_t state, stateNext;
    logic [6:0] opcode, f7;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic legal;

    function automatic logic regOk(input logic [4:0] r);
        return NUM_REGS == 32 || !r[4];
    endfunction

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign f3     = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign f7     = ir[31:25];

    // only the register fields a format actually uses are range-checked
    assign legal = (opcode == OP_RTYPE && regOk(rs1) && regOk(rs2) && regOk(rd) &&
                    ((f7 == F7_ZERO && f3 inside {F3_ADD, F3_SLL, F3_SLTU, F3_SRL, F3_OR, F3_AND}) ||
                     (f7 == F7_SUB && f3 == F3_ADD))) ||
                   (opcode == OP_IMM && f3 == F3_ADD && regOk(rs1) && regOk(rd)) ||
                   (opcode == OP_LUI && regOk(rd)) ||
                   (opcode == OP_BRANCH && f3 != 3'b010 && f3 != 3'b011 && regOk(rs1) && regOk(rs2)) ||
                   (opcode == OP_JAL && regOk(rd));

    assign branch    = opcode == OP_BRANCH;
    assign jump      = opcode == OP_JAL;
    assign aluSrcImm = opcode == OP_IMM;
    assign wdSrc     = opcode == OP_LUI ? WD_IMMU : opcode == OP_JAL ? WD_PC4 : WD_ALU;
    assign aluControl = opcode != OP_RTYPE ? ALU_ADD :
                        f3 == F3_ADD  ? (f7[5] ? ALU_SUB : ALU_ADD) :
                        f3 == F3_SLL  ? ALU_SLL :
                        f3 == F3_SLTU ? ALU_SLTU :
                        f3 == F3_SRL  ? ALU_SRL :
                        f3 == F3_OR   ? ALU_OR : ALU_AND;

    assign irWrite  = state == FETCH && imValid;
    assign regWrite = state == WRITEBACK && !branch && rd != 5'd0;
    assign pcWrite  = state == WRITEBACK;

    assign stateNext = state == FETCH     ? (imValid ? DECODE : FETCH) :
                       state == DECODE    ? (legal ? EXECUTE : HALT) :
                       state == EXECUTE   ? WRITEBACK :
                       state == WRITEBACK ? FETCH : HALT;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state  <= FETCH;
            imReq  <= 1'b1;
            halted <= 1'b0;
            retire <= 1'b0;
        end else begin
            state  <= stateNext;
            imReq  <= stateNext == FETCH;
            halted <= stateNext == HALT;
            retire <= stateNext == WRITEBACK;
        end
endmodule

// File: rtl/sr_cpu_multicycle.sv
// sr_cpu_multicycle: multi-cycle RV32I-subset core, datapath, register file and ALU.
// Define SR_CPU_MULTICYCLE_PERF_EN to build the cycle/instret counters.
module sr_cpu_multicycle
    import sr_cpu_multicycle_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NUM_REGS = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    sr_cpu_multicycle_if.master   im,
    input  logic [4:0]            regAddr,
    output logic [31:0]           regData,
    output logic                  halted,
    output logic                  retire,
    output logic [31:0]           cycleCnt,
    output logic [31:0]           instretCnt
);
    localparam int RW = $clog2(NUM_REGS);

    logic [31:0] pc, ir, a, b, imm, aluOut, srcB, aluResult, wd, pcPlus4, pcTarget;
    logic [31:0] rf [NUM_REGS];
    logic takeBranch, takeBranchNext, imReq;
    logic irWrite, regWrite, pcWrite, aluSrcImm, branch, jump;
    wdSrc_t wdSrc;
    aluOp_t aluControl;

    sr_mc_control #(.NUM_REGS(NUM_REGS)) control (
        .clk(clk), .rst(rst), .ir(ir), .imValid(im.imValid), .imReq(imReq),
        .irWrite(irWrite), .regWrite(regWrite), .pcWrite(pcWrite), .aluSrcImm(aluSrcImm),
        .branch(branch), .jump(jump), .halted(halted), .retire(retire),
        .wdSrc(wdSrc), .aluControl(aluControl)
    );

    function automatic logic [31:0] rfRead(input logic [4:0] r);
        return (r == 5'd0 || 32'(r) >= NUM_REGS) ? 32'b0 : rf[r[RW-1:0]];
    endfunction

    assign im.imReq  = imReq;
    assign im.imAddr = {2'b00, pc[31:2]};
    assign regData   = regAddr != 5'd0 ? rfRead(regAddr) : pc;

    assign srcB = aluSrcImm ? imm : b;
    assign aluResult = aluControl == ALU_ADD ? a + srcB :
                       aluControl == ALU_SUB ? a - srcB :
                       aluControl == ALU_AND ? a & srcB :
                       aluControl == ALU_OR  ? a | srcB :
                       aluControl == ALU_SLL ? a << srcB[4:0] :
                       aluControl == ALU_SRL ? a >> srcB[4:0] : {31'b0, a < srcB};
    assign takeBranchNext = ir[14:12] == F3_BEQ  ? a == b :
                            ir[14:12] == F3_BNE  ? a != b :
                            ir[14:12] == F3_BLT  ? $signed(a) < $signed(b) :
                            ir[14:12] == F3_BGE  ? $signed(a) >= $signed(b) :
                            ir[14:12] == F3_BLTU ? a < b : a >= b;

    assign pcPlus4  = pc + 32'd4;
    assign pcTarget = pc + imm;
    assign wd = wdSrc == WD_IMMU ? imm : wdSrc == WD_PC4 ? pcPlus4 : aluOut;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            pc <= RESET_PC;
            ir <= 32'b0;
        end else begin
            if (irWrite) ir <= im.imData;
            if (pcWrite) pc <= (jump || (branch && takeBranch)) ? pcTarget : pcPlus4;
        end

    // operand/result latches load every cycle; IR and the regfile are stable between the uses
    always_ff @(posedge clk) begin
        a          <= rfRead(ir[19:15]);
        b          <= rfRead(ir[24:20]);
        imm        <= immGen(ir);
        aluOut     <= aluResult;
        takeBranch <= takeBranchNext;
        if (regWrite) rf[ir[7 +: RW]] <= wd;
    end

`ifdef SR_CPU_MULTICYCLE_PERF_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cycleCnt   <= 32'b0;
            instretCnt <= 32'b0;
        end else begin
            cycleCnt   <= cycleCnt + 32'd1;
            instretCnt <= instretCnt + {31'b0, retire};
        end
`else
    assign cycleCnt   = 32'b0;
    assign instretCnt = 32'b0;
`endif
endmodule

// File: tb/tb_sr_cpu_multicycle.sv
// tb_sr_cpu_multicycle: directed program runs on two core configurations with a retire scoreboard
module tb_sr_cpu_multicycle;
    logic clk = 1'b0, rstA = 1'b1, rstB = 1'b1;
    logic [4:0] regAddrA = 5'd0, regAddrB = 5'd0;
    logic [31:0] regDataA, regDataB, cycA, instA, cycB, instB, d;
    logic haltA, haltB, retA, retB;
    int nChecks = 0, nFails = 0, waitA = 0, cntA, retCntA, retCntB, perfCyc, cyc, nProgA;
    logic [31:0] memA [256];
    logic [31:0] memB [256];

    typedef struct {logic [31:0] pc; logic [4:0] rd; logic [31:0] val; logic [31:0] next;} exp_t;
    exp_t sb[$];
    exp_t e;

    sr_cpu_multicycle_if imA();
    sr_cpu_multicycle_if imB();

    sr_cpu_multicycle #(.RESET_PC(32'h100), .NUM_REGS(32)) dutA (
        .clk(clk), .rst(rstA), .im(imA), .regAddr(regAddrA), .regData(regDataA),
        .halted(haltA), .retire(retA), .cycleCnt(cycA), .instretCnt(instA));
    sr_cpu_multicycle #(.RESET_PC(32'h20), .NUM_REGS(16)) dutB (
        .clk(clk), .rst(rstB), .im(imB), .regAddr(regAddrB), .regData(regDataB),
        .halted(haltB), .retire(retB), .cycleCnt(cycB), .instretCnt(instB));

    always #5 clk = ~clk;

    assign imA.imValid = imA.imReq && cntA >= waitA;
    assign imA.imData  = memA[imA.imAddr[7:0]];
    assign imB.imValid = imB.imReq;
    assign imB.imData  = memB[imB.imAddr[7:0]];

    always_ff @(posedge clk or posedge rstA)
        if (rstA) begin
            cntA <= 0;
            retCntA <= 0;
            perfCyc <= 0;
        end else begin
            cntA <= (imA.imValid || !imA.imReq) ? 0 : cntA + 1;
            retCntA <= retCntA + int'(retA);
            perfCyc <= perfCyc + 1;
        end

    always_ff @(posedge clk or posedge rstB)
        if (rstB) retCntB <= 0;
        else retCntB <= retCntB + int'(retB);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic readA(input logic [4:0] a, output logic [31:0] v);
        regAddrA = a;
        #1 v = regDataA;
    endtask

    task automatic readB(input logic [4:0] a, output logic [31:0] v);
        regAddrB = a;
        #1 v = regDataB;
    endtask

    // counts cycles from the current FETCH sample point to the retire pulse
    task automatic runOne(input bit useB, input logic [31:0] addr, output int n);
        n = 1;
        while (!(useB ? retB : retA) && n < 40) begin
            if (useB ? imB.imReq : imA.imReq) check("imAddr hold", useB ? imB.imAddr : imA.imAddr, addr);
            @(posedge clk);
            #1 n++;
        end
    endtask

    function automatic logic [31:0] encR(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] encI(input logic [11:0] imm, input logic [4:0] rs1, rd);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] encB(input int off, input logic [4:0] rs1, rs2, input logic [2:0] f3);
        logic [12:0] i;
        i = 13'(off);
        return {i[12], i[10:5], rs2, rs1, f3, i[4:1], i[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] encJ(input int off, input logic [4:0] rd);
        logic [20:0] i;
        i = 21'(off);
        return {i[20], i[10:1], i[11], i[19:12], rd, 7'b1101111};
    endfunction

    task automatic put(input logic [31:0] pc, instr, input logic [4:0] rd, input logic [31:0] val, next);
        memA[pc[9:2]] = instr;
        sb.push_back('{pc, rd, val, next});
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            memA[i] = 32'b0;
            memB[i] = 32'b0;
        end
        put(32'h100, 32'h00500093, 5'd1, 32'd5, 32'h104);
        put(32'h104, encI(12'hFFF, 5'd0, 5'd1), 5'd1, 32'hFFFF_FFFF, 32'h108);
        put(32'h108, encI(12'd1, 5'd0, 5'd2), 5'd2, 32'd1, 32'h10C);
        put(32'h10C, encB(8, 5'd1, 5'd2, 3'b100), 5'd1, 32'hFFFF_FFFF, 32'h114);
        put(32'h114, encB(8, 5'd1, 5'd2, 3'b110), 5'd2, 32'd1, 32'h118);
        put(32'h118, encR(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 5'd3, 32'd0, 32'h11C);
        put(32'h11C, encR(7'h20, 5'd1, 5'd2, 3'b000, 5'd4), 5'd4, 32'd2, 32'h120);
        put(32'h120, encR(7'h00, 5'd2, 5'd1, 3'b001, 5'd5), 5'd5, 32'hFFFF_FFFE, 32'h124);
        put(32'h124, encR(7'h00, 5'd2, 5'd1, 3'b101, 5'd6), 5'd6, 32'h7FFF_FFFF, 32'h128);
        put(32'h128, encR(7'h00, 5'd1, 5'd2, 3'b011, 5'd7), 5'd7, 32'd1, 32'h12C);
        put(32'h12C, encR(7'h00, 5'd4, 5'd1, 3'b111, 5'd8), 5'd8, 32'd2, 32'h130);
        put(32'h130, encR(7'h00, 5'd2, 5'd4, 3'b110, 5'd9), 5'd9, 32'd3, 32'h134);
        put(32'h134, {20'h12345, 5'd10, 7'b0110111}, 5'd10, 32'h1234_5000, 32'h138);
        put(32'h138, encB(8, 5'd1, 5'd1, 3'b000), 5'd10, 32'h1234_5000, 32'h140);
        put(32'h140, encB(8, 5'd1, 5'd1, 3'b001), 5'd3, 32'd0, 32'h144);
        put(32'h144, encB(8, 5'd2, 5'd1, 3'b101), 5'd4, 32'd2, 32'h14C);
        put(32'h14C, encB(8, 5'd2, 5'd1, 3'b111), 5'd5, 32'hFFFF_FFFE, 32'h150);
        nProgA = sb.size();
        memB[8]  = encJ(16, 5'd1);
        memB[12] = encI(12'd1, 5'd0, 5'd20);

        #12;
        @(negedge clk) rstA = 1'b0;
        check("reset imReq", 32'(imA.imReq), 32'd1);
        check("reset imAddr", imA.imAddr, 32'h40);
        check("reset halted", 32'(haltA), 32'd0);
        check("reset retire", 32'(retA), 32'd0);
        readA(5'd0, d);
        check("reset pc", d, 32'h100);

        while (sb.size() > 0) begin
            e = sb.pop_front();
            runOne(1'b0, e.pc >> 2, cyc);
            check("retire cycle", 32'(cyc), 32'd4);
            @(posedge clk);
            #1 check("next imAddr", imA.imAddr, e.next >> 2);
            readA(e.rd, d);
            check("rd value", d, e.val);
            readA(5'd0, d);
            check("next pc", d, e.next);
        end

        @(posedge clk);
        #1 check("decode not halted", 32'(haltA), 32'd0);
        @(posedge clk);
        #1 check("halted", 32'(haltA), 32'd1);
        check("halt imReq", 32'(imA.imReq), 32'd0);
        check("halt retire", 32'(retA), 32'd0);
        repeat (3) @(posedge clk);
        #1 readA(5'd0, d);
        check("halt pc frozen", d, 32'h150);
        check("retire count", 32'(retCntA), 32'(nProgA));
`ifdef SR_CPU_MULTICYCLE_PERF_EN
        check("instretCnt", instA, 32'(retCntA));
        check("cycleCnt", cycA, 32'(perfCyc));
`else
        check("instretCnt tied", instA, 32'd0);
        check("cycleCnt tied", cycA, 32'd0);
`endif

        waitA = 3;
        @(negedge clk) rstA = 1'b1;
        @(negedge clk) rstA = 1'b0;
        check("wait reset halted", 32'(haltA), 32'd0);
        runOne(1'b0, 32'h40, cyc);
        check("wait retire cycle", 32'(cyc), 32'd7);
        @(posedge clk);
        #1 readA(5'd1, d);
        check("wait x1", d, 32'd5);
        readA(5'd0, d);
        check("wait next pc", d, 32'h104);

        waitA = 5;
        @(posedge clk);
        @(posedge clk);
        #3 rstA = 1'b1;
        #1 check("abandon imReq", 32'(imA.imReq), 32'd1);
        check("abandon imAddr", imA.imAddr, 32'h40);
        readA(5'd0, d);
        check("abandon pc", d, 32'h100);
        @(negedge clk) begin
            waitA = 0;
            rstA = 1'b0;
        end
        runOne(1'b0, 32'h40, cyc);
        check("restart retire cycle", 32'(cyc), 32'd4);
        @(posedge clk);
        #1 readA(5'd1, d);
        check("restart x1", d, 32'd5);

        @(negedge clk) rstB = 1'b0;
        readB(5'd0, d);
        check("B reset pc", d, 32'h20);
        runOne(1'b1, 32'h8, cyc);
        check("jal retire cycle", 32'(cyc), 32'd4);
        @(posedge clk);
        #1 readB(5'd1, d);
        check("jal link", d, 32'h24);
        readB(5'd0, d);
        check("jal target", d, 32'h30);
        @(posedge clk);
        @(posedge clk);
        #1 check("rv32e halted", 32'(haltB), 32'd1);
        check("rv32e imReq", 32'(imB.imReq), 32'd0);
        readB(5'd20, d);
        check("x20 unchanged", d, 32'd0);
        readB(5'd0, d);
        check("rv32e pc frozen", d, 32'h30);
        repeat (2) @(posedge clk);
        #1 check("rv32e retire count", 32'(retCntB), 32'd1);
`ifdef SR_CPU_MULTICYCLE_PERF_EN
        check("B instretCnt", instB, 32'(retCntB));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
